// File: rtl/mem_stage_pkg.sv
// Shared constants for the memory-access stage: opcode layout, funct3 codes, FSM states.
// Combinational helpers only; no latency or flow control of its own.
package mem_stage_pkg;

   localparam int OPCODE_WIDTH = 10;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_e;

   // Index of the final beat: 1, 2 or 4 bytes per access.
   function automatic logic [1:0] last_beat(input logic [2:0] funct3);
      case (funct3[1:0])
         2'b00:   return 2'd0;
         2'b01:   return 2'd1;
         default: return 2'd3;
      endcase
   endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Pipeline-side and byte-memory-side signals of the memory stage (misalign_err only with MEM_ALIGN_CHECK_EN).
// slave = the stage itself; master = the surrounding pipeline and memory.
interface mem_stage_if;
   import mem_stage_pkg::*;

   logic [OPCODE_WIDTH:0] opcode_in;
   logic [31:0]           data_in;
   logic [31:0]           scrdata_in;
   logic [4:0]            Rd_in;
   logic [31:0]           data_out;
   logic [4:0]            Rd_out;
   logic                  wb_en;
   logic                  busy_line;
   logic                  mem_req;
   logic                  mem_we;
   logic [31:0]           mem_addr;
   logic [7:0]            mem_wdata;
   logic                  mem_ack;
   logic [7:0]            mem_rdata;
`ifdef MEM_ALIGN_CHECK_EN
   logic                  misalign_err;
`endif

   modport slave (
      input  opcode_in, data_in, scrdata_in, Rd_in, mem_ack, mem_rdata,
      output data_out, Rd_out, wb_en, busy_line, mem_req, mem_we, mem_addr, mem_wdata
`ifdef MEM_ALIGN_CHECK_EN
      , output misalign_err
`endif
   );

   modport master (
      output opcode_in, data_in, scrdata_in, Rd_in, mem_ack, mem_rdata,
      input  data_out, Rd_out, wb_en, busy_line, mem_req, mem_we, mem_addr, mem_wdata
`ifdef MEM_ALIGN_CHECK_EN
      , input misalign_err
`endif
   );

endinterface

// File: rtl/mem_load_ext.sv
// Sign/zero extension of an assembled little-endian load value by funct3.
// Purely combinational, zero latency, no flow control.
module mem_load_ext
   import mem_stage_pkg::*;
(
   input  logic [2:0]  funct3_i,
   input  logic [31:0] raw_i,
   output logic [31:0] ext_o
);

   always_comb begin
      ext_o = raw_i;
      case (funct3_i)
         F3_LB:   ext_o = {{24{raw_i[7]}}, raw_i[7:0]};
         F3_LH:   ext_o = {{16{raw_i[15]}}, raw_i[15:0]};
         F3_LW:   ext_o = raw_i;
         F3_LBU:  ext_o = {24'd0, raw_i[7:0]};
         F3_LHU:  ext_o = {16'd0, raw_i[15:0]};
         default: ext_o = raw_i;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: pass-through with zero latency, loads/stores as N byte beats; busy_line stalls the pipe N+1 cycles
// plus one per cycle mem_ack is low. MEM_ALIGN_CHECK_EN rejects misaligned half/word accesses.
module mem_stage
   import mem_stage_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   mem_stage_if.slave   bus
);

   state_e      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] asm_q, asm_d;
   logic [4:0]  rd_q, rd_d;
   logic [2:0]  f3_q, f3_d;
   logic [1:0]  last_q, last_d;
   logic [1:0]  k_q, k_d;
   logic        store_q, store_d;
   logic        err_q, err_d;
   logic [31:0] ext_val;
   logic [6:0]  major;
   logic        is_mem;
   logic        misaligned;
   logic        unused_f7;

   assign major     = bus.opcode_in[6:0];
   assign is_mem    = (major == OP_LOAD) || (major == OP_STORE);
   assign unused_f7 = bus.opcode_in[OPCODE_WIDTH];

`ifdef MEM_ALIGN_CHECK_EN
   always_comb begin
      misaligned = 1'b0;
      if (bus.opcode_in[8:7] == 2'b01)
         misaligned = bus.data_in[0];
      else if (bus.opcode_in[8])
         misaligned = |bus.data_in[1:0];
   end
   assign bus.misalign_err = (state_q == DONE) && err_q;
`else
   assign misaligned = 1'b0;
`endif

   mem_load_ext u_ext (
      .funct3_i (f3_q),
      .raw_i    (asm_q),
      .ext_o    (ext_val)
   );

   always_comb begin
      state_d       = state_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      asm_d         = asm_q;
      rd_d          = rd_q;
      f3_d          = f3_q;
      last_d        = last_q;
      k_d           = k_q;
      store_d       = store_q;
      err_d         = err_q;
      bus.data_out  = 32'd0;
      bus.Rd_out    = 5'd0;
      bus.wb_en     = 1'b0;
      bus.busy_line = 1'b0;
      bus.mem_req   = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = 32'd0;
      bus.mem_wdata = 8'd0;

      case (state_q)
         IDLE: begin
            if (is_mem) begin
               bus.busy_line = 1'b1;
               addr_d        = bus.data_in;
               wdata_d       = bus.scrdata_in;
               rd_d          = bus.Rd_in;
               f3_d          = bus.opcode_in[9:7];
               last_d        = last_beat(bus.opcode_in[9:7]);
               store_d       = (major == OP_STORE);
               k_d           = 2'd0;
               asm_d         = 32'd0;
               err_d         = misaligned;
               state_d       = misaligned ? DONE : ACCESS;
            end else begin
               bus.data_out = bus.data_in;
               bus.Rd_out   = bus.Rd_in;
               bus.wb_en    = (major != OP_STORE) && (major != OP_BRANCH) &&
                              (|bus.opcode_in) && (|bus.Rd_in);
            end
         end
         ACCESS: begin
            bus.busy_line = 1'b1;
            bus.mem_req   = 1'b1;
            bus.mem_we    = store_q;
            bus.mem_addr  = addr_q + 32'(k_q);
            bus.mem_wdata = store_q ? wdata_q[{k_q, 3'b000} +: 8] : 8'd0;
            if (bus.mem_ack) begin
               if (!store_q)
                  asm_d[{k_q, 3'b000} +: 8] = bus.mem_rdata;
               k_d = k_q + 2'd1;
               if (k_q == last_q)
                  state_d = DONE;
            end
         end
         DONE: begin
            // Upstream advances on this edge, so IDLE sees the next instruction.
            bus.Rd_out = rd_q;
            if (!store_q && !err_q) begin
               bus.data_out = ext_val;
               bus.wb_en    = |rd_q;
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         asm_q   <= 32'd0;
         rd_q    <= 5'd0;
         f3_q    <= 3'd0;
         last_q  <= 2'd0;
         k_q     <= 2'd0;
         store_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         asm_q   <= asm_d;
         rd_q    <= rd_d;
         f3_q    <= f3_d;
         last_q  <= last_d;
         k_q     <= k_d;
         store_q <= store_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboarded bench for mem_stage: expected beats/results queued at drive time, checked by a negedge monitor.
module tb_mem_stage;
   import mem_stage_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mem_stage_if bif();

   mem_stage dut (
      .clk (clk),
      .rst (rst),
      .bus (bif.slave)
   );

   logic [7:0] tb_mem [0:1023];
   assign bif.mem_rdata = tb_mem[bif.mem_addr[9:0]];

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [7:0]  wdata;
   } beat_t;

   typedef struct {
      logic [31:0] data;
      logic [4:0]  rd;
      logic        wb;
      int          busy;
      logic        err;
   } res_t;

   beat_t beat_q[$];
   res_t  res_q[$];
   beat_t mb;
   res_t  mr;
   int    n_chk  = 0;
   int    n_fail = 0;
   int    busy_cnt = 0;
   logic  prev_busy = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
      end
   endtask

   // Monitor: beats are checked as they are acked, results when busy_line falls.
   always @(negedge clk) begin
      if (rst) begin
         busy_cnt  = 0;
         prev_busy = 1'b0;
      end else begin
         if (bif.mem_req && bif.mem_ack) begin
            if (beat_q.size() == 0) begin
               check_eq("unexpected_beat", 32'd1, 32'd0);
            end else begin
               mb = beat_q.pop_front();
               check_eq("beat_addr", bif.mem_addr, mb.addr);
               check_eq("beat_we", 32'(bif.mem_we), 32'(mb.we));
               if (mb.we)
                  check_eq("beat_wdata", 32'(bif.mem_wdata), 32'(mb.wdata));
            end
         end
         if (bif.busy_line) begin
            busy_cnt++;
         end else if (prev_busy) begin
            if (res_q.size() == 0) begin
               check_eq("unexpected_done", 32'd1, 32'd0);
            end else begin
               mr = res_q.pop_front();
               check_eq("done_data", bif.data_out, mr.data);
               check_eq("done_rd", 32'(bif.Rd_out), 32'(mr.rd));
               check_eq("done_wb_en", 32'(bif.wb_en), 32'(mr.wb));
               check_eq("busy_cycles", 32'(busy_cnt), 32'(mr.busy));
`ifdef MEM_ALIGN_CHECK_EN
               check_eq("misalign_err", 32'(bif.misalign_err), 32'(mr.err));
`endif
            end
            busy_cnt = 0;
         end
         prev_busy = bif.busy_line;
      end
   end

   task automatic drive_idle();
      bif.opcode_in  = '0;
      bif.data_in    = 32'd0;
      bif.scrdata_in = 32'd0;
      bif.Rd_in      = 5'd0;
      bif.mem_ack    = 1'b0;
   endtask

   task automatic do_mem(input logic [6:0] major, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] sdata, input logic [4:0] rd, input int stall_beat,
                         input int stall_cycles, input logic [31:0] exp_data);
      int    n;
      int    beats;
      int    left;
      logic  done;
      logic  is_st;
      logic  mis;
      beat_t b;
      res_t  r;
      n     = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      is_st = (major == OP_STORE);
      mis   = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      mis = (n == 2 && addr[0]) || (n == 4 && addr[1:0] != 2'b00);
`endif
      if (!mis) begin
         for (int i = 0; i < n; i++) begin
            b.addr  = addr + 32'(i);
            b.we    = is_st;
            b.wdata = sdata[8*i +: 8];
            beat_q.push_back(b);
         end
      end
      r.data = (is_st || mis) ? 32'd0 : exp_data;
      r.rd   = rd;
      r.wb   = !is_st && !mis && (rd != 5'd0);
      r.busy = mis ? 1 : n + 1 + stall_cycles;
      r.err  = mis;
      res_q.push_back(r);

      @(posedge clk); #1;
      bif.opcode_in  = {1'b0, f3, major};
      bif.data_in    = addr;
      bif.scrdata_in = sdata;
      bif.Rd_in      = rd;
      bif.mem_ack    = 1'b1;
      beats = 0;
      left  = stall_cycles;
      done  = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge clk);
         if (!bif.busy_line) begin
            done = 1'b1;
         end else begin
            if (!bif.mem_ack) begin
               check_eq("stall_req_held", 32'(bif.mem_req), 32'd1);
               check_eq("stall_addr_held", bif.mem_addr, addr + 32'(beats));
               left--;
            end else if (bif.mem_req) begin
               beats++;
            end
            @(posedge clk); #1;
            bif.mem_ack = (beats == stall_beat && left > 0) ? 1'b0 : 1'b1;
         end
      end
      if (!done) check_eq("access_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      drive_idle();
   endtask

   task automatic do_rst_mid();
      beat_t b;
      int    beats;
      for (int i = 0; i < 4; i++) begin
         b.addr = 32'h100 + 32'(i);
         b.we   = 1'b0;
         b.wdata = 8'd0;
         beat_q.push_back(b);
      end
      @(posedge clk); #1;
      bif.opcode_in = {1'b0, F3_LW, OP_LOAD};
      bif.data_in   = 32'h100;
      bif.Rd_in     = 5'd9;
      bif.mem_ack   = 1'b1;
      beats = 0;
      for (int c = 0; c < 20 && beats < 2; c++) begin
         @(negedge clk);
         if (bif.mem_req && bif.mem_ack) beats++;
      end
      check_eq("rst_mid_beats", 32'(beats), 32'd2);
      @(posedge clk); #1;
      rst = 1'b1;
      drive_idle();
      @(posedge clk); #1;
      rst = 1'b0;
      beat_q.delete();
      @(negedge clk);
      check_eq("rst_mid_mem_req", 32'(bif.mem_req), 32'd0);
      check_eq("rst_mid_busy", 32'(bif.busy_line), 32'd0);
      check_eq("rst_mid_wb_en", 32'(bif.wb_en), 32'd0);
      check_eq("rst_mid_data", bif.data_out, 32'd0);
   endtask

   // Pass-through table: opcode, data, rd, expected wb_en.
   logic [10:0] pt_op [6] = '{11'h033, 11'h033, 11'h063, 11'h000, 11'h037, 11'h013};
   logic [31:0] pt_dat[6] = '{32'h12345678, 32'hCAFEF00D, 32'h0000_0040, 32'h0000_1111, 32'hABCD_0000, 32'hFFFF_FFFF};
   logic [4:0]  pt_rd [6] = '{5'd5, 5'd0, 5'd5, 5'd5, 5'd1, 5'd31};
   logic        pt_wb [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

   initial begin
      for (int i = 0; i < 1024; i++) tb_mem[i] = 8'h00;
      tb_mem[10'h100] = 8'h11; tb_mem[10'h101] = 8'h22;
      tb_mem[10'h102] = 8'h33; tb_mem[10'h103] = 8'h44;
      tb_mem[10'h104] = 8'h55;
      tb_mem[10'h040] = 8'h80; tb_mem[10'h041] = 8'h7F;

      rst = 1'b1;
      drive_idle();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_eq("rst_data_out", bif.data_out, 32'd0);
      check_eq("rst_rd_out", 32'(bif.Rd_out), 32'd0);
      check_eq("rst_wb_en", 32'(bif.wb_en), 32'd0);
      check_eq("rst_busy", 32'(bif.busy_line), 32'd0);
      check_eq("rst_mem_req", 32'(bif.mem_req), 32'd0);
      check_eq("rst_mem_we", 32'(bif.mem_we), 32'd0);
      check_eq("rst_mem_addr", bif.mem_addr, 32'd0);
      check_eq("rst_mem_wdata", 32'(bif.mem_wdata), 32'd0);

      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         bif.opcode_in = pt_op[i];
         bif.data_in   = pt_dat[i];
         bif.Rd_in     = pt_rd[i];
         #1;
         check_eq("pt_data", bif.data_out, pt_dat[i]);
         check_eq("pt_rd", 32'(bif.Rd_out), 32'(pt_rd[i]));
         check_eq("pt_wb_en", 32'(bif.wb_en), 32'(pt_wb[i]));
         check_eq("pt_busy", 32'(bif.busy_line), 32'd0);
      end
      @(posedge clk); #1;
      drive_idle();

      do_mem(OP_LOAD,  F3_LW,  32'h100, 32'd0,        5'd3, 99, 0, 32'h44332211);
      do_mem(OP_LOAD,  F3_LB,  32'h040, 32'd0,        5'd4, 99, 0, 32'hFFFFFF80);
      do_mem(OP_LOAD,  F3_LBU, 32'h040, 32'd0,        5'd4, 99, 0, 32'h00000080);
      do_mem(OP_LOAD,  F3_LH,  32'h040, 32'd0,        5'd6, 99, 0, 32'h00007F80);
      do_mem(OP_STORE, F3_SH,  32'h202, 32'hDEADBEEF, 5'd7, 99, 0, 32'd0);
      do_mem(OP_LOAD,  F3_LH,  32'h040, 32'd0,        5'd8,  1, 3, 32'h00007F80);
      do_mem(OP_LOAD,  F3_LHU, 32'h040, 32'd0,        5'd0, 99, 0, 32'h00007F80);
      do_mem(OP_STORE, F3_SB,  32'h300, 32'h123456A5, 5'd2, 99, 0, 32'd0);
      do_mem(OP_STORE, F3_SW,  32'h310, 32'hA1B2C3D4, 5'd0,  2, 2, 32'd0);
      do_mem(OP_LOAD,  F3_LW,  32'h101, 32'd0,        5'd1, 99, 0, 32'h55443322);
      do_mem(OP_LOAD,  F3_LB,  32'h103, 32'd0,        5'd1, 99, 0, 32'h00000044);

      do_rst_mid();

      repeat (2) @(posedge clk);
      check_eq("beat_q_empty", 32'(beat_q.size()), 32'd0);
      check_eq("res_q_empty", 32'(res_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage logic between the EX/MEM pipeline register and the MEM/WB register. It consumes the decoded opcode, ALU result, store data and destination register produced by EX/MEM. Loads and stores run as a sequence of byte beats on an 8-bit memory port. ALU results pass straight through. While an access is in flight, the block holds `busy_line` high so the upstream and downstream pipeline registers stall.

## Interface
- `OPCODE_WIDTH`, default 10: MSB index of the opcode bus, so the bus is `[OPCODE_WIDTH:0]`, 11 bits. Bit layout:
  - [6:0] major opcode
  - [9:7] funct3
  - [10] funct7[5]
- `clk`  in  1  clock
- `rst`  in  1  reset: one clock; reset is synchronous and active-high
- `opcode_in`  in  OPCODE_WIDTH+1  opcode from EX/MEM
- `data_in`  in  32  ALU result, or effective address for loads/stores
- `scrdata_in`  in  32  store data (rs2)
- `Rd_in`  in  5  destination register
- `data_out`  out  32  writeback value to MEM/WB
- `Rd_out`  out  5  destination register to MEM/WB
- `wb_en`  out  1  register-file write enable to MEM/WB
- `busy_line`  out  1  pipeline stall request
- `mem_req`  out  1  memory beat request
- `mem_we`  out  1  1 = write beat
- `mem_addr`  out  32  byte address of the current beat
- `mem_wdata`  out  8  write byte
- `mem_ack`  in  1  beat accepted; `mem_rdata` is valid this cycle
- `mem_rdata`  in  8  read byte

## Operation
- States:
  - IDLE: no access in progress.
  - ACCESS: issuing beats.
  - DONE: one cycle that presents the result.
- A memory instruction is `opcode_in[6:0]` equal to LOAD (0000011) or STORE (0100011).
- IDLE with a memory instruction:
  - `busy_line`=1, combinationally.
  - Latch the following:
    - address = `data_in`
    - store data
    - `Rd_in`
    - funct3
    - beat count N: funct3[1:0] 00→1, 01→2, 1x→4
  - Clear the beat counter k and the assembly register, then go to ACCESS.
- IDLE with any other opcode: pure pass-through.
  - `data_out`=`data_in`, `Rd_out`=`Rd_in`.
  - `wb_en`=1 unless the major opcode is STORE or BRANCH (1100011), the opcode is all-zero (bubble), or `Rd_in`=0.
- ACCESS behaviour:
  - `mem_req`=1, `mem_addr`=latched address + k, modulo 2^32.
  - `mem_we`=1 for a store, with `mem_wdata` = store byte k.
  - On `mem_req && mem_ack`: a load writes `mem_rdata` into assembly bits [8k+7:8k]; then k increments.
  - After beat N-1 is acked, go to DONE.
  - `busy_line`=1 throughout.
  - `mem_ack` has no effect while `mem_req`=0.
- DONE behaviour:
  - `busy_line`=0 and `Rd_out` = latched Rd.
  - Load: `data_out` = assembled value, extended per funct3. LB/LH sign-extend; LBU/LHU zero-extend; LW uses all 32 bits.
  - Load: `wb_en`=1 if Rd≠0.
  - Store: `wb_en`=0 and `data_out`=0.
  - Next state is always IDLE. The upstream instruction advances on this edge, so the access never re-triggers.
- Byte order is little-endian. Misaligned addresses are legal unless the configured check is enabled.

## Timing
- Reset values: state IDLE, k=0, latched registers 0. Every output is 0 in the cycle after `rst` is sampled.
- Reset mid-access: the access is abandoned. `mem_req` and `busy_line` are 0 in the first cycle after reset, and no partial writeback occurs.
- With `mem_ack` held high, an N-byte access stalls for N+1 cycles and completes in DONE at cycle N+1.
- Each cycle with `mem_ack` low adds one cycle. `mem_addr`, `mem_we` and `mem_wdata` stay stable until the beat is acked.
- Pass-through has zero latency: outputs follow the inputs combinationally in IDLE.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined:
  - A half access with addr[0]≠0, or a word access with addr[1:0]≠0, issues no beats.
  - The block goes IDLE→DONE, with `busy_line` high for one cycle.
  - In DONE: output `misalign_err`=1 for one cycle, `wb_en`=0, `data_out`=0.
  - `misalign_err` resets to 0.
- `MEM_ALIGN_CHECK_EN` undefined: the `misalign_err` port is absent and misaligned accesses execute bytewise as normal.

## Structure
- Shared package/header holds:
  - `OPCODE_WIDTH`
  - LOAD, STORE and BRANCH major-opcode constants
  - funct3 encodings LB/LH/LW/LBU/LHU/SB/SH/SW
  - state encoding IDLE/ACCESS/DONE
- One sub-module, `mem_load_ext`: a combinational block that maps funct3 and the 32-bit assembly value to the extended load result.

## Test plan
- LW at 0x100, memory 0x11/0x22/0x33/0x44, ack every cycle:
  - `mem_addr` steps 0x100..0x103.
  - DONE gives `data_out`=0x44332211 and `wb_en`=1.
  - `busy_line` is high for 5 cycles.
- Byte 0x80 at 0x40:
  - LB gives 0xFFFFFF80.
  - LBU gives 0x00000080.
  - LH of 0x80,0x7F gives 0x00007F80.
- SH at 0x202, `scrdata_in`=0xDEADBEEF:
  - Two write beats: 0xEF@0x202, then 0xBE@0x203.
  - DONE gives `wb_en`=0.
- LH with `mem_ack` low for 3 cycles before the second beat:
  - `mem_addr` is held at addr+1 and `mem_req` stays 1.
  - `busy_line` is high for 6 cycles in total.
- `rst` pulse after 2 acked beats of an LW: the next cycle shows `mem_req`=0, `busy_line`=0, `wb_en`=0 and `data_out`=0.
- Pass-through: ADD opcode 0110011, `data_in`=0x12345678, `Rd_in`=5 gives, in the same cycle, `data_out`=0x12345678, `Rd_out`=5, `wb_en`=1 and `busy_line`=0.
- With `MEM_ALIGN_CHECK_EN`: LW at 0x101 gives no `mem_req`, and `misalign_err`=1 for one cycle.
